countdown16: RTL and testbench
==============================

Name: countdown16

Overview:
- Loadable 16-bit down-counter/timer.
- Counts from a loaded value to zero and emits a one-cycle terminal-count pulse.
- Supports one-shot and auto-reload modes, with a programmable prescaler on the count enable.
- Used alongside the free-running up counter as the interval/timeout source in the same SmartFusion2 fabric designs.

Parameters:
- WIDTH, 16: counter and load-value width in bits.
- PRESCALE, 1: number of enabled clk cycles per decrement; legal range 1..65535. A value of 1 means decrement on every enabled cycle.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  start/reload value, captured when load=1.
- en  input  1  count enable; when 0, the prescaler and Q freeze.
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled at terminal tick.
- Q  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse; high for exactly one cycle.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE (one-shot expired).

Behaviour:
- Reset (rst=0, asynchronous; takes effect immediately, regardless of clk):
  - Q=0, tc=0, busy=0, done=0.
  - Reload register=0, prescale count=0, state=IDLE.
  - Release is synchronous to the first clk edge with rst=1.
  - Reset mid-count aborts with no tc.
- States:
  - IDLE: Q holds, busy=0, done=0.
  - RUN: counting, busy=1.
  - DONE: Q=0, busy=0, done=1.
- tick = (state==RUN) && en && (prescale count == PRESCALE-1).
  - The prescale count increments only when state==RUN and en=1, and wraps to 0 on tick.
- load=1 (any state, highest priority):
  - Q<=load_val, reload register<=load_val, prescale count<=0, tc<=0.
  - load_val != 0 -> RUN.
  - load_val == 0 -> IDLE with Q=0; no tc is ever generated.
  - Load coinciding with a tick: load wins, no decrement, no tc.
- RUN, tick, Q>1: Q<=Q-1; tc=0.
- RUN, tick, Q==1 (terminal tick):
  - tc<=1 for the next cycle only.
  - mode=1: Q<=reload register, stay in RUN (periodic; period = reload*PRESCALE enabled cycles).
  - mode=0: Q<=0, go to DONE.
- RUN, no tick: Q holds, tc=0.
- DONE: holds until load; en ignored. IDLE likewise holds until load.
- Output timing:
  - tc is registered: it is high in the same cycle that Q first shows the post-terminal value (0, or the reload value).
  - busy and done are decoded from registered state; no combinational path from inputs to outputs.
- Latency:
  - Load value visible on Q 1 cycle after the load edge.
  - With PRESCALE=1 and en held high, tc is asserted exactly N cycles after the load edge for load_val=N.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - Q never underflows: decrement from 1 is the terminal case, and Q=0 is never in RUN.
  - load_val=16'hFFFF is legal (65535 ticks).
- mode changes mid-run take effect at the next terminal tick only.

Test Plan:
- Reset, then load_val=5, load pulse, en=1, mode=0, PRESCALE=1 -> Q: 5,4,3,2,1,0 on successive cycles; tc=1 exactly in the cycle Q becomes 0; done=1 and busy=0 thereafter; Q stays 0 for 10 more cycles.
- Auto-reload: load_val=3, mode=1, en=1 -> Q sequence 3,2,1,3,2,1,3; tc high on each return to 3 (every 3 cycles); busy stays 1.
- Prescale/enable: PRESCALE=4, load_val=2, en toggled 1,0,1,... -> Q decrements only after 4 enabled cycles; tc after 8 enabled cycles (16 clk); Q and prescale frozen while en=0.
- Simultaneous events:
  - load_val=7 asserted on the same edge as the terminal tick of a running count -> Q=7, tc stays 0, state RUN.
  - load_val=0 -> Q=0, IDLE, tc never asserted.
- Async reset: assert rst=0 between clk edges while Q=9 in RUN -> Q=0, busy=0, tc=0 immediately without a clk edge. After release, no counting occurs until a load.
- Boundary: load_val=16'hFFFF, mode=0, PRESCALE=1 -> tc exactly 65535 cycles after load; Q never wraps to FFFF after 0.

Source files
------------

// File: rtl/countdown16_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown16_if
// Description : Control/status bundle for the countdown16 interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown16_if #(
    parameter int WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, en, mode,
        input  Q, tc, busy, done
    );

    modport slave (
        input  load, load_val, en, mode,
        output Q, tc, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/countdown16.sv
`default_nettype none
// ============================================================================
// Module      : countdown16
// Description : Loadable down-counter/timer with prescaler, one-shot and
//               auto-reload modes, and a registered terminal-count pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown16 #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    countdown16_if.slave      bus
);

    localparam int              c_PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PS_LAST = c_PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic [c_PW-1:0]  r_ps, w_ps_nxt;
    logic             r_tc, w_tc_nxt;
    logic             w_tick;

    assign w_tick = (r_state == S_RUN) && bus.en && (r_ps == c_PS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_ps     <= '0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_reload <= w_reload_nxt;
            r_ps     <= w_ps_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_ps_nxt     = r_ps;
        w_tc_nxt     = 1'b0;

        // Load overrides everything, including a coincident terminal tick.
        if (bus.load) begin
            w_q_nxt      = bus.load_val;
            w_reload_nxt = bus.load_val;
            w_ps_nxt     = '0;
            w_state_nxt  = (bus.load_val != '0) ? S_RUN : S_IDLE;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_tick) begin
                        w_ps_nxt = '0;
                        if (r_q == WIDTH'(1)) begin
                            w_tc_nxt = 1'b1;
                            if (bus.mode) begin
                                w_q_nxt = r_reload;
                            end else begin
                                w_q_nxt     = '0;
                                w_state_nxt = S_DONE;
                            end
                        end else begin
                            w_q_nxt = r_q - WIDTH'(1);
                        end
                    end else if (bus.en) begin
                        w_ps_nxt = r_ps + c_PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Q    = r_q;
    assign bus.tc   = r_tc;
    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_countdown16.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown16
// Description : Self-checking bench for countdown16 (PRESCALE 1 and 4 in parallel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown16;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] load_val;
    logic        en;
    logic        mode;

    int n_tests = 0;
    int n_fail  = 0;

    countdown16_if #(.WIDTH(16)) if1 ();
    countdown16_if #(.WIDTH(16)) if4 ();

    assign if1.load = load;  assign if1.load_val = load_val;
    assign if1.en   = en;    assign if1.mode     = mode;
    assign if4.load = load;  assign if4.load_val = load_val;
    assign if4.en   = en;    assign if4.mode     = mode;

    countdown16 #(.WIDTH(16), .PRESCALE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    countdown16 #(.WIDTH(16), .PRESCALE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    always #5 clk = ~clk;

    // Reference: count enabled cycles since load/reload; Q follows by division.
    int unsigned ps_of  [2] = '{1, 4};
    int unsigned m_rel  [2] = '{0, 0};
    int unsigned m_el   [2] = '{0, 0};
    bit          m_run  [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};
    bit          m_tc   [2] = '{0, 0};

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_rel[k] = 0; m_el[k] = 0; m_run[k] = 0; m_done[k] = 0; m_tc[k] = 0;
            end else begin
                m_tc[k] = 0;
                if (load) begin
                    m_rel[k]  = load_val;
                    m_el[k]   = 0;
                    m_run[k]  = (load_val != 0);
                    m_done[k] = 0;
                end else if (m_run[k] && en) begin
                    m_el[k]++;
                    if (m_el[k] == m_rel[k] * ps_of[k]) begin
                        m_tc[k] = 1;
                        m_el[k] = 0;
                        if (!mode) begin
                            m_run[k]  = 0;
                            m_done[k] = 1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [31:0] exp_q(int k);
        return m_run[k] ? (m_rel[k] - m_el[k] / ps_of[k]) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("p1_q",    32'(if1.Q),    exp_q(0));
        chk("p1_tc",   32'(if1.tc),   32'(m_tc[0]));
        chk("p1_busy", 32'(if1.busy), 32'(m_run[0]));
        chk("p1_done", 32'(if1.done), 32'(m_done[0]));
        chk("p4_q",    32'(if4.Q),    exp_q(1));
        chk("p4_tc",   32'(if4.tc),   32'(m_tc[1]));
        chk("p4_busy", 32'(if4.busy), 32'(m_run[1]));
        chk("p4_done", 32'(if4.done), 32'(m_done[1]));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    int n;
    logic [15:0] seq3 [7] = '{16'd3, 16'd2, 16'd1, 16'd3, 16'd2, 16'd1, 16'd3};

    initial begin
        rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; mode = 1'b0;
        repeat (3) step();
        chk("rst_q", 32'(if1.Q), 32'd0);
        rst = 1'b1;
        repeat (2) step();

        // One-shot, load 5
        load = 1'b1; load_val = 16'd5; en = 1'b1; mode = 1'b0;
        step();
        load = 1'b0;
        chk("os_q0", 32'(if1.Q), 32'd5);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("os_seq", 32'(if1.Q), 32'(5 - i));
            chk("os_tc", 32'(if1.tc), 32'(i == 5));
        end
        repeat (10) step();
        chk("os_hold_q", 32'(if1.Q), 32'd0);
        chk("os_done", 32'(if1.done), 32'd1);

        // Auto-reload, load 3
        load = 1'b1; load_val = 16'd3; mode = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            chk("ar_seq", 32'(if1.Q), 32'(seq3[i]));
            chk("ar_tc", 32'(if1.tc), 32'(i > 0 && i % 3 == 0));
            chk("ar_busy", 32'(if1.busy), 32'd1);
        end

        // Prescale with en toggling: tc of the PRESCALE=4 unit 16 clocks after load
        load = 1'b1; load_val = 16'd2; mode = 1'b0;
        step();
        load = 1'b0; en = 1'b0;
        n = 0;
        while (!if4.tc && n < 100) begin
            step();
            n++;
            en = ~en;
        end
        chk("ps_lat", 32'(n), 32'd16);
        en = 1'b1;

        // Load coinciding with terminal tick
        load = 1'b1; load_val = 16'd3; mode = 1'b0;
        step();
        load = 1'b0;
        step();
        step();
        chk("sim_pre", 32'(if1.Q), 32'd1);
        load = 1'b1; load_val = 16'd7;
        step();
        load = 1'b0;
        chk("sim_q", 32'(if1.Q), 32'd7);
        chk("sim_tc", 32'(if1.tc), 32'd0);
        chk("sim_busy", 32'(if1.busy), 32'd1);

        // Load of zero
        load = 1'b1; load_val = 16'd0;
        step();
        load = 1'b0;
        repeat (4) step();
        chk("z_busy", 32'(if1.busy), 32'd0);

        // Async reset between edges while Q=9
        load = 1'b1; load_val = 16'd9;
        step();
        load = 1'b0;
        chk("ar9_q", 32'(if1.Q), 32'd9);
        #3 rst = 1'b0;
        #1;
        chk("async_q", 32'(if1.Q), 32'd0);
        chk("async_busy", 32'(if1.busy), 32'd0);
        check_all();
        step();
        rst = 1'b1;
        repeat (5) step();
        chk("post_rst_q", 32'(if1.Q), 32'd0);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            load     = ($urandom_range(0, 15) == 0);
            load_val = 16'($urandom_range(0, 12));
            en       = ($urandom_range(0, 3) != 0);
            mode     = 1'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #3 rst = 1'b0;
                #1 check_all();
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end

        // Full-range one-shot
        load = 1'b1; load_val = 16'hFFFF; mode = 1'b0; en = 1'b1;
        step();
        load = 1'b0;
        n = 0;
        while (!if1.tc && n < 70000) begin
            step();
            n++;
        end
        chk("ffff_lat", 32'(n), 32'd65535);
        repeat (3) step();
        chk("ffff_q", 32'(if1.Q), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
